// File: rtl/regfile_scoreboard.sv
// 32 x XLEN register file with per-register pending-write counters.
// Provides operand bypass, RAW stall detection and issue back-pressure.
module regfile_scoreboard #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      rs1Addr_ID,
    input  logic [4:0]      rs2Addr_ID,
    output logic [XLEN-1:0] rs1Data_ID,
    output logic [XLEN-1:0] rs2Data_ID,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rdAddr,
    input  logic            issue_regWrite,
    output logic            issue_ready,
    output logic            stall_ID,
    input  logic [4:0]      rdAddr_WB,
    input  logic            regWrite_WB,
    input  logic [XLEN-1:0] rdData_WB,
    input  logic            kill_valid,
    input  logic [4:0]      kill_rdAddr,
    input  logic [4:0]      dbgAddr,
    output logic [XLEN-1:0] dbgData,
    output logic            sb_err
);

    localparam int SW = CNT_W + 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [XLEN-1:0]  regs    [32];
    logic [CNT_W-1:0] cnt     [32];
    logic [CNT_W-1:0] cnt_nxt [32];
    logic [31:0]      dec_wb;
    logic [31:0]      dec_k;
    logic [31:0]      inc;
    logic             haz1;
    logic             haz2;
    logic             accept;
    logic             err_set;
    logic             err_q;

    // One-hot decrement requests from writeback and kill (x0 excluded)
    always_comb begin
        dec_wb = '0;
        dec_k  = '0;
        if (regWrite_WB && rdAddr_WB != 5'd0)
            dec_wb[rdAddr_WB] = 1'b1;
        if (kill_valid && kill_rdAddr != 5'd0)
            dec_k[kill_rdAddr] = 1'b1;
    end

    // Hazard if writes remain pending after this cycle's retirements
    always_comb begin
        haz1 = (rs1Addr_ID != 5'd0) &&
               (SW'(cnt[rs1Addr_ID]) >
                SW'(dec_wb[rs1Addr_ID]) + SW'(dec_k[rs1Addr_ID]));
        haz2 = (rs2Addr_ID != 5'd0) &&
               (SW'(cnt[rs2Addr_ID]) >
                SW'(dec_wb[rs2Addr_ID]) + SW'(dec_k[rs2Addr_ID]));
        stall_ID = haz1 || haz2;
    end

    // Back-pressure when the destination counter is saturated
    always_comb begin
        issue_ready = !(issue_regWrite &&
                        issue_rdAddr != 5'd0 &&
                        cnt[issue_rdAddr] == CNT_MAX &&
                        !dec_wb[issue_rdAddr] &&
                        !dec_k[issue_rdAddr]);
        accept = issue_valid && issue_ready && !stall_ID;
        inc = '0;
        if (accept && issue_regWrite && issue_rdAddr != 5'd0)
            inc[issue_rdAddr] = 1'b1;
    end

    // Counter next-state with underflow clamp and overflow hold
    always_comb begin
        logic [SW-1:0] sum;
        logic [SW-1:0] dec;
        err_set = 1'b0;
        sum = '0;
        dec = '0;
        for (int r = 0; r < 32; r++) begin
            sum = SW'(cnt[r]) + SW'(inc[r]);
            dec = SW'(dec_wb[r]) + SW'(dec_k[r]);
            if (sum < dec) begin
                cnt_nxt[r] = '0;
                err_set = 1'b1;
            end else if (sum - dec > SW'(CNT_MAX)) begin
                cnt_nxt[r] = cnt[r];
                err_set = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum - dec);
            end
        end
    end

    // Register array writes from writeback; kill never touches data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (regWrite_WB && rdAddr_WB != 5'd0) begin
            regs[rdAddr_WB] <= rdData_WB;
        end
    end

    // Pending-write counters and sticky error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++)
                cnt[i] <= cnt_nxt[i];
            if (err_set)
                err_q <= 1'b1;
        end
    end

    assign sb_err = err_q;

    assign rs1Data_ID =
        (rs1Addr_ID == 5'd0) ? '0 :
        (regWrite_WB && rdAddr_WB == rs1Addr_ID) ? rdData_WB :
        regs[rs1Addr_ID];

    assign rs2Data_ID =
        (rs2Addr_ID == 5'd0) ? '0 :
        (regWrite_WB && rdAddr_WB == rs2Addr_ID) ? rdData_WB :
        regs[rs2Addr_ID];

    assign dbgData =
        (dbgAddr == 5'd0) ? '0 :
        (regWrite_WB && rdAddr_WB == dbgAddr) ? rdData_WB :
        regs[dbgAddr];

endmodule
